// File: rtl/mem_layout_pkg.sv
// Shared memory-layout definitions for the BRAM loader/generator path.
// Exposes the stream word width and the loader state encoding for probing.
package mem_layout;

    localparam int unsigned WORD_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        PACK,
        WRITE,
        DRAIN,
        DONE
    } loader_state_t;

endpackage

// File: rtl/bram_loader.sv
// Packs a 32-bit AXI-Stream into DATA_WIDTH-bit lines and writes them to sequential
// BRAM addresses, then hands the buffer to the generator on tlast or when the BRAM fills.
module bram_loader
    import mem_layout::*;
#(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned BRAM_DEPTH = 512
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WORD_WIDTH-1:0]         s_tdata,
    input  logic                          s_tvalid,
    input  logic                          s_tlast,
    output logic                          s_tready,
    input  logic                          write_rdy,
    input  logic                          restart,
    output logic [$clog2(BRAM_DEPTH)-1:0] addr,
    output logic [DATA_WIDTH-1:0]         line_in,
    output logic                          we,
    output logic                          en,
    output logic                          generator_mode,
    output logic                          rst_gen_mode,
    output logic [$clog2(BRAM_DEPTH):0]   load_len,
    output logic                          load_done,
    output logic                          overflow
);

    localparam int unsigned LANES = DATA_WIDTH / WORD_WIDTH;
    localparam int unsigned AW    = $clog2(BRAM_DEPTH);
    localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(BRAM_DEPTH - 1);
    localparam logic [AW:0]   FULL_LEN  = (AW + 1)'(BRAM_DEPTH);

    loader_state_t         state_q, state_d;
    logic [LW-1:0]         lane_q;
    logic [AW-1:0]         addr_q;
    logic [DATA_WIDTH-1:0] line_q;
    logic [AW:0]           load_len_q;
    logic                  tlast_q, overflow_q, rst_gen_q, load_done_q;
    logic                  abort, accept;

    // restart is ignored in IDLE and overrides every other transition elsewhere
    assign abort  = restart && (state_q != IDLE);
    assign accept = s_tvalid && s_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (write_rdy) state_d = PACK;
                PACK:  if (accept && (s_tlast || lane_q == LAST_LANE)) state_d = WRITE;
                WRITE: begin
                    if (we) begin
                        if (tlast_q)               state_d = DONE;
                        else if (addr_q == LAST_ADDR) state_d = DRAIN;
                        else                       state_d = PACK;
                    end
                end
                DRAIN: if (accept && s_tlast) state_d = DONE;
                DONE:  state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        s_tready       = 1'b0;
        we             = 1'b0;
        generator_mode = 1'b0;
        case (state_q)
            PACK, DRAIN: s_tready       = !abort;
            WRITE:       we             = write_rdy && !abort;
            DONE:        generator_mode = 1'b1;
            default:     ;
        endcase
    end

    assign en = we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q      <= '0;
            addr_q      <= '0;
            line_q      <= '0;
            load_len_q  <= '0;
            tlast_q     <= 1'b0;
            overflow_q  <= 1'b0;
            rst_gen_q   <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            rst_gen_q   <= abort;
            load_done_q <= 1'b0;
            if (abort) begin
                lane_q     <= '0;
                addr_q     <= '0;
                line_q     <= '0;
                tlast_q    <= 1'b0;
                overflow_q <= 1'b0;
            end else begin
                case (state_q)
                    PACK: begin
                        if (accept) begin
                            for (int unsigned k = 0; k < LANES; k++) begin
                                if (lane_q == LW'(k)) begin
                                    line_q[k*WORD_WIDTH +: WORD_WIDTH] <= s_tdata;
                                end
                            end
                            lane_q  <= lane_q + 1'b1;
                            tlast_q <= s_tlast;
                        end
                    end
                    WRITE: begin
                        if (we) begin
                            // Clearing here zero-fills the lanes a short final line leaves empty
                            line_q <= '0;
                            lane_q <= '0;
                            if (addr_q != LAST_ADDR) addr_q <= addr_q + 1'b1;
                            if (tlast_q) begin
                                load_done_q <= 1'b1;
                                load_len_q  <= {1'b0, addr_q} + 1'b1;
                            end else if (addr_q == LAST_ADDR) begin
                                overflow_q <= 1'b1;
                            end
                        end
                    end
                    DRAIN: begin
                        if (accept && s_tlast) begin
                            load_done_q <= 1'b1;
                            load_len_q  <= FULL_LEN;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign addr         = addr_q;
    assign line_in      = line_q;
    assign load_len     = load_len_q;
    assign load_done    = load_done_q;
    assign rst_gen_mode = rst_gen_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_bram_loader.sv
// Bench for bram_loader: two instances (deep and 4-line BRAM) driven through a shared,
// select-gated stream; a frame-level packing model and a write monitor check every write.
module tb_bram_loader;
    import mem_layout::*;

    localparam int DW      = 256;
    localparam int LANES   = DW / 32;
    localparam int DEPTH_A = 512;
    localparam int DEPTH_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, sel, s_tvalid, s_tlast, write_rdy, restart;
    logic [31:0] s_tdata;

    logic          tready_a, we_a, en_a, gm_a, rgm_a, done_a, ovf_a;
    logic [8:0]    addr_a;
    logic [9:0]    len_a;
    logic [DW-1:0] line_a;
    logic          tready_b, we_b, en_b, gm_b, rgm_b, done_b, ovf_b;
    logic [1:0]    addr_b;
    logic [2:0]    len_b;
    logic [DW-1:0] line_b;

    logic          m_tready, m_we, m_en, m_gm, m_rgm, m_done, m_ovf;
    int            m_addr, m_len;
    logic [DW-1:0] m_line;

    bram_loader #(.DATA_WIDTH(DW), .BRAM_DEPTH(DEPTH_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid && !sel),
        .s_tlast(s_tlast), .s_tready(tready_a), .write_rdy(write_rdy && !sel),
        .restart(restart && !sel), .addr(addr_a), .line_in(line_a), .we(we_a), .en(en_a),
        .generator_mode(gm_a), .rst_gen_mode(rgm_a), .load_len(len_a), .load_done(done_a),
        .overflow(ovf_a)
    );

    bram_loader #(.DATA_WIDTH(DW), .BRAM_DEPTH(DEPTH_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid && sel),
        .s_tlast(s_tlast), .s_tready(tready_b), .write_rdy(write_rdy && sel),
        .restart(restart && sel), .addr(addr_b), .line_in(line_b), .we(we_b), .en(en_b),
        .generator_mode(gm_b), .rst_gen_mode(rgm_b), .load_len(len_b), .load_done(done_b),
        .overflow(ovf_b)
    );

    always_comb begin
        m_tready = sel ? tready_b : tready_a;
        m_we     = sel ? we_b : we_a;
        m_en     = sel ? en_b : en_a;
        m_gm     = sel ? gm_b : gm_a;
        m_rgm    = sel ? rgm_b : rgm_a;
        m_done   = sel ? done_b : done_a;
        m_ovf    = sel ? ovf_b : ovf_a;
        m_addr   = sel ? int'(addr_b) : int'(addr_a);
        m_len    = sel ? int'(len_b) : int'(len_a);
        m_line   = sel ? line_b : line_a;
    end

    int            checks = 0;
    int            errors = 0;
    int            wr_idx = 0;
    int            done_cnt = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mem[0:DEPTH_A-1];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Write monitor: every BRAM write must be the next expected line at the next address
    always @(negedge clk) begin
        if (rst_n) begin
            chk_i("we_eq_en", 32'(m_we), 32'(m_en));
            if (m_done) done_cnt++;
            if (m_we) begin
                chk_i("we_needs_write_rdy", 32'(write_rdy), 32'd1);
                chk_i("no_tready_during_write", 32'(m_tready), 32'd0);
                if (wr_idx < exp_q.size()) begin
                    chk_i("write_addr", m_addr, wr_idx);
                    chk("write_line", m_line, exp_q[wr_idx]);
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL extra_write actual=addr %0d required=no write", m_addr);
                end
                mem[m_addr] = m_line;
                wr_idx++;
            end
        end
    end

    function automatic int cur_depth();
        return sel ? DEPTH_B : DEPTH_A;
    endfunction

    // Frame model: n words base, base+1, ... packed lane 0 first, zero-filled, capped at depth
    task automatic build_model(input int n, input logic [31:0] base);
        int nl, kept;
        logic [DW-1:0] ln;
        nl   = (n + LANES - 1) / LANES;
        kept = (nl < cur_depth()) ? nl : cur_depth();
        exp_q.delete();
        wr_idx   = 0;
        done_cnt = 0;
        for (int l = 0; l < kept; l++) begin
            ln = '0;
            for (int k = 0; k < LANES; k++) begin
                if (l * LANES + k < n) ln[k*32 +: 32] = base + 32'(l * LANES + k);
            end
            exp_q.push_back(ln);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        int t;
        s_tdata  = d;
        s_tvalid = 1'b1;
        s_tlast  = last;
        t = 0;
        @(negedge clk);
        while (!m_tready && t < 300) begin
            t++;
            @(negedge clk);
        end
        if (!m_tready) begin
            checks++;
            errors++;
            $display("FAIL tready_timeout actual=0 required=1 word=%h", d);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic stall5();
        write_rdy = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk_i("stall_we", 32'(m_we), 32'd0);
            chk_i("stall_en", 32'(m_en), 32'd0);
            chk_i("stall_tready", 32'(m_tready), 32'd0);
            chk_i("stall_state", 32'(dut_a.state_q), 32'(WRITE));
        end
        @(posedge clk);
        #1;
        write_rdy = 1'b1;
    endtask

    task automatic run_frame(input int n, input logic [31:0] base, input int stall_at,
                             input int gap_max);
        int nl, kept, t;
        nl   = (n + LANES - 1) / LANES;
        kept = (nl < cur_depth()) ? nl : cur_depth();
        build_model(n, base);
        for (int i = 0; i < n; i++) begin
            if (gap_max > 0 && $urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, gap_max)) @(posedge clk);
                #1;
            end
            if (i == n - 1) begin
                chk_i("no_done_before_last", done_cnt, 0);
                chk_i("no_gen_before_last", 32'(m_gm), 32'd0);
            end
            send_word(base + 32'(i), i == n - 1);
            if (i == stall_at) stall5();
        end
        t = 0;
        @(negedge clk);
        while (!m_gm && t < 100) begin
            t++;
            @(negedge clk);
        end
        chk_i("generator_mode", 32'(m_gm), 32'd1);
        chk_i("load_done_with_gen", 32'(m_done), 32'd1);
        @(negedge clk);
        chk_i("load_done_once", done_cnt, 1);
        chk_i("write_count", wr_idx, kept);
        chk_i("load_len", m_len, kept);
        chk_i("overflow", 32'(m_ovf), 32'(nl > kept));
        for (int i = 0; i < kept; i++) chk("readback", mem[i], exp_q[i]);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_restart();
        int held;
        held    = m_len;
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        @(negedge clk);
        chk_i("rst_gen_pulse", 32'(m_rgm), 32'd1);
        chk_i("gen_cleared", 32'(m_gm), 32'd0);
        chk_i("addr_cleared", m_addr, 0);
        chk_i("overflow_cleared", 32'(m_ovf), 32'd0);
        chk("line_cleared", m_line, '0);
        chk_i("load_len_held", m_len, held);
        if (!sel) chk_i("state_idle", 32'(dut_a.state_q), 32'(IDLE));
        @(negedge clk);
        chk_i("rst_gen_one_cycle", 32'(m_rgm), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; sel = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
        write_rdy = 1'b0; restart = 1'b0;
        #12;
        chk_i("rst_tready", 32'(m_tready), 32'd0);
        chk_i("rst_we", 32'(m_we), 32'd0);
        chk_i("rst_gen", 32'(m_gm), 32'd0);
        chk_i("rst_rgm", 32'(m_rgm), 32'd0);
        chk_i("rst_done", 32'(m_done), 32'd0);
        chk_i("rst_ovf", 32'(m_ovf), 32'd0);
        chk_i("rst_addr", m_addr, 0);
        chk_i("rst_len", m_len, 0);
        chk("rst_line", m_line, '0);
        sel = 1'b1;
        #1;
        chk_i("rst_b_tready", 32'(m_tready), 32'd0);
        chk_i("rst_b_len", m_len, 0);
        sel = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        write_rdy = 1'b1;

        // Two full lines
        run_frame(16, 32'h1000_0000, -1, 0);
        chk_i("lit_line0_lane7", mem[0][255:224], 32'h1000_0007);
        chk_i("lit_line1_lane0", mem[1][31:0], 32'h1000_0008);
        pulse_restart();

        // Short frame: lanes 3..7 zero
        run_frame(3, 32'h0000_00A0, -1, 0);
        chk("lit_short_line", mem[0], {160'd0, 32'hA2, 32'hA1, 32'hA0});
        chk_i("lit_short_len", m_len, 1);
        pulse_restart();

        // write_rdy low for 5 cycles while the first line waits in WRITE
        run_frame(16, 32'h2000_0000, 7, 0);
        pulse_restart();

        // Abandon a partial frame, then a fresh 8-word frame
        build_model(0, 32'h0);
        for (int i = 0; i < 5; i++) send_word(32'h3000_0000 + 32'(i), 1'b0);
        pulse_restart();
        chk_i("no_partial_write", wr_idx, 0);
        run_frame(8, 32'h4000_0000, -1, 0);
        chk_i("lit_after_restart_len", m_len, 1);
        pulse_restart();

        // 4-line BRAM: overflow with drained tail, then an exact fit
        sel = 1'b1;
        run_frame(40, 32'hB000_0000, -1, 0);
        chk_i("lit_ovf_last_word", mem[3][255:224], 32'hB000_001F);
        chk_i("lit_ovf_flag", 32'(m_ovf), 32'd1);
        pulse_restart();
        run_frame(32, 32'hC000_0000, -1, 0);
        chk_i("lit_exact_fit_len", m_len, 4);
        pulse_restart();
        sel = 1'b0;

        // Asynchronous reset mid-frame
        build_model(10, 32'h5000_0000);
        for (int i = 0; i < 10; i++) send_word(32'h5000_0000 + 32'(i), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_i("async_rst_addr", m_addr, 0);
        chk_i("async_rst_tready", 32'(m_tready), 32'd0);
        chk_i("async_rst_we", 32'(m_we), 32'd0);
        chk_i("async_rst_len", m_len, 0);
        chk("async_rst_line", m_line, '0);
        chk_i("async_rst_one_write", wr_idx, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 100 lines with random valid gaps
        run_frame(100 * LANES, 32'h6000_0000, -1, 20);
        chk_i("lit_long_len", m_len, 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_loader.md
# bram_loader

Upstream write stage for `bram_intf`. It accepts a 32-bit AXI-Stream sample stream and packs consecutive words into `DATA_WIDTH`-bit lines. It writes those lines to sequential BRAM addresses through `bram_intf`'s write port. When the frame ends (`s_tlast`) or the BRAM is full, it hands the buffer to the generator by asserting `generator_mode`.

## Interface
- `DATA_WIDTH`, 256, BRAM line width; multiple of `WORD_WIDTH`
- `BRAM_DEPTH`, 512, number of BRAM lines; power of two, ≥ 2
- `WORD_WIDTH`, 32, stream word width (fixed; from package)
- `clk`  in  1  sole clock
- `rst_n`  in  1  asynchronous, active-low reset
- `s_tdata`  in  `WORD_WIDTH`  stream word
- `s_tvalid`  in  1  word valid
- `s_tlast`  in  1  last word of frame
- `s_tready`  out  1  word accepted when `s_tvalid && s_tready`
- `write_rdy`  in  1  `bram_intf` ready to accept writes
- `restart`  in  1  single-cycle request to abandon or finish the load and start a new one
- `addr`  out  `$clog2(BRAM_DEPTH)`  BRAM write address
- `line_in`  out  `DATA_WIDTH`  packed line
- `we`, `en`  out  1  BRAM write strobe and enable (always equal)
- `generator_mode`  out  1  buffer handed to generator
- `rst_gen_mode`  out  1  one-cycle pulse clearing generator state
- `load_len`  out  `$clog2(BRAM_DEPTH)+1`  lines written in last completed load
- `load_done`  out  1  one-cycle pulse on entry to DONE
- `overflow`  out  1  sticky; frame exceeded `BRAM_DEPTH` lines

## Operation
- Let `LANES = DATA_WIDTH/WORD_WIDTH`.
- The first word of a line goes to `line_in[31:0]`. Lane k goes to `[32k +: 32]`.
- States:
  - IDLE → PACK when `write_rdy`=1.
  - PACK: `s_tready`=1. Accepted words fill lanes via lane counter `lane`.
    - Go to WRITE when lane `LANES-1` is accepted, or when `s_tlast` is accepted.
    - On early `s_tlast`, unfilled lanes are zero.
  - WRITE: `s_tready`=0. `we=en=1` only while `write_rdy`=1; otherwise stall with strobes low. After the write cycle, `addr`+1 and `lane`=0.
    - tlast seen → DONE.
    - Else if the written address was `BRAM_DEPTH-1` → DRAIN with `overflow`=1.
    - Else → PACK.
  - DRAIN: `s_tready`=1. Words are discarded. The accepted `s_tlast` → DONE.
  - DONE: `generator_mode`=1. `load_len` = lines written (1..`BRAM_DEPTH`). `s_tready`=0.
- `restart`, in any state other than IDLE:
  - Next cycle: `rst_gen_mode`=1 for one cycle, `generator_mode`=0.
  - `addr`, `lane`, `line_in`, `overflow` cleared; `load_len` held.
  - Partial line discarded; state → IDLE.
  - `restart` in IDLE is ignored.
- `restart` has priority over every other transition in the same cycle.
- `addr` never wraps. The full case always takes the DRAIN path.

## Timing
- Reset value of every output is 0, including `s_tready`, `line_in` and `load_len`. State = IDLE.
- IDLE→PACK: 1 cycle after `write_rdy` is seen high.
- Last-lane handshake at cycle n → `we`=1 at cycle n+1 (if `write_rdy`). `addr` shows the next line at n+2.
- Steady-state throughput: `LANES` words per `LANES+1` cycles.
- `load_done` and `generator_mode` rise in the cycle after the final WRITE or the DRAIN `s_tlast` handshake.
- `rst_n` deasserted mid-load: the immediate asynchronous return to reset values is the required behaviour, with no write issued.

## Structure
- Shared package (`mem_layout`):
  - `WORD_WIDTH`
  - `loader_state_t` enum {IDLE, PACK, WRITE, DRAIN, DONE}, so benches can probe state
- Single module. Lane packing stays inline; no sub-module.
- The bench instantiates `bram_loader` → `bram_intf` and checks generator readback.

## Test plan
- `DATA_WIDTH`=256, 16 words with `tlast` on word 16 → 2 writes at `addr` 0,1; `load_len`=2; `generator_mode`=1; readback matches.
- 3 words with `tlast`, then nothing → 1 write, lanes 3..7 = 0; `load_len`=1.
- `BRAM_DEPTH`=4, 40 words, `tlast` on word 40:
  - 4 writes
  - `overflow`=1
  - words 33..40 accepted and dropped
  - `load_done` after word 40
- `write_rdy` low for 5 cycles during WRITE → strobes low and `s_tready`=0 for those cycles; data intact.
- `restart` after 5 words of a frame:
  - `rst_gen_mode` pulse of 1 cycle
  - `addr`=0 and state IDLE
  - a new 8-word frame → `load_len`=1
- Random `s_tvalid` gaps (1–20 cycles), 100 lines → all lines correct; `load_done` exactly once.
